// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: FSM encodings and op-flag indices.
// Imported by every pipeline stage that decodes the op-class flags.
package memory_access_pkg;

  localparam int N_OPS  = 4;
  localparam int OP_ALU = 0;
  localparam int OP_CMP = 1;
  localparam int OP_LD  = 2;
  localparam int OP_STR = 3;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACCESS = 1'b1;

  typedef logic [N_OPS-1:0] op_flags_t;

  function automatic logic [2:0] count_flags(input op_flags_t flags);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < N_OPS; i++) begin
      cnt = cnt + 3'(flags[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/memory_access_dmem_timer.sv
// Wait counter for outstanding data-memory accesses; expired fires on the last
// permitted wait cycle so the FSM can give up at that cycle's closing edge.
module dmem_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Counter reaches TIMEOUT at the coming edge: this is the final wait cycle.
  assign expired = enable && (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: ALU/compare results pass through in one cycle,
// loads and stores stall upstream while a data-memory handshake is in flight.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [3:0]  rd_num_in,
  input  logic [31:0] result_in,
  input  logic [31:0] store_val_in,
  input  logic [31:0] cpsr_in,
  input  logic        is_alu_op_in,
  input  logic        is_cmp_op_in,
  input  logic        is_ld_op_in,
  input  logic        is_str_op_in,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [3:0]  rd_num_passthrough,
  output logic [31:0] result,
  output logic [31:0] mem_passthrough,
  output logic [31:0] cpsr_passthrough,
  output logic [31:0] dmem_val_passthrough,
  output logic        is_alu_op_passthrough,
  output logic        is_cmp_op_passthrough,
  output logic        is_ld_op_passthrough,
  output logic        err
);

  logic [0:0] state_reg;
  logic [3:0] rd_lat_reg;
  logic       ld_pending_reg;
  op_flags_t  op_flags;
  logic       is_idle;
  logic       multi_flag;
  logic       accept_mem;
  logic       timer_enable;
  logic       timer_expired;

  assign op_flags[OP_ALU] = is_alu_op_in;
  assign op_flags[OP_CMP] = is_cmp_op_in;
  assign op_flags[OP_LD]  = is_ld_op_in;
  assign op_flags[OP_STR] = is_str_op_in;

  assign is_idle    = (state_reg == ST_IDLE);
  assign multi_flag = valid_in && (count_flags(op_flags) > 3'd1);
  assign accept_mem = is_idle && valid_in && !multi_flag
                      && (op_flags[OP_LD] || op_flags[OP_STR]);

  assign stall = (state_reg == ST_ACCESS);

  // An ack on the final wait cycle must win, so the timer only runs without ack.
  assign timer_enable = (state_reg == ST_ACCESS) && !dmem_ack;

  dmem_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_dmem_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept_mem),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg             <= ST_IDLE;
      rd_lat_reg            <= '0;
      ld_pending_reg        <= 1'b0;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= '0;
      dmem_wdata            <= '0;
      rd_num_passthrough    <= '0;
      result                <= '0;
      mem_passthrough       <= '0;
      cpsr_passthrough      <= '0;
      dmem_val_passthrough  <= '0;
      is_alu_op_passthrough <= 1'b0;
      is_cmp_op_passthrough <= 1'b0;
      is_ld_op_passthrough  <= 1'b0;
      err                   <= 1'b0;
    end else begin
      // Writeback sees a bubble unless a branch below produces an instruction.
      is_alu_op_passthrough <= 1'b0;
      is_cmp_op_passthrough <= 1'b0;
      is_ld_op_passthrough  <= 1'b0;
      err                   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          mem_passthrough <= result_in;
          if (multi_flag) begin
            err <= 1'b1;
          end else if (valid_in && (op_flags[OP_ALU] || op_flags[OP_CMP])) begin
            rd_num_passthrough    <= rd_num_in;
            result                <= result_in;
            cpsr_passthrough      <= cpsr_in;
            is_alu_op_passthrough <= op_flags[OP_ALU];
            is_cmp_op_passthrough <= op_flags[OP_CMP];
          end else if (accept_mem) begin
            rd_lat_reg     <= rd_num_in;
            ld_pending_reg <= op_flags[OP_LD];
            dmem_addr      <= result_in;
            dmem_wdata     <= store_val_in;
            dmem_req       <= 1'b1;
            dmem_we        <= op_flags[OP_STR];
            state_reg      <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          if (dmem_ack) begin
            dmem_req           <= 1'b0;
            dmem_we            <= 1'b0;
            rd_num_passthrough <= rd_lat_reg;
            mem_passthrough    <= dmem_addr;
            if (ld_pending_reg) begin
              dmem_val_passthrough <= dmem_rdata;
              is_ld_op_passthrough <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end else if (timer_expired) begin
            dmem_req  <= 1'b0;
            dmem_we   <= 1'b0;
            err       <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through ops, load/store handshakes,
// timeout, ack-vs-timeout race, illegal flags and mid-access reset.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [3:0]  rd_num_in = '0;
  logic [31:0] result_in = '0;
  logic [31:0] store_val_in = '0;
  logic [31:0] cpsr_in = '0;
  logic        is_alu_op_in = 1'b0;
  logic        is_cmp_op_in = 1'b0;
  logic        is_ld_op_in = 1'b0;
  logic        is_str_op_in = 1'b0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [3:0]  rd_num_passthrough;
  logic [31:0] result;
  logic [31:0] mem_passthrough;
  logic [31:0] cpsr_passthrough;
  logic [31:0] dmem_val_passthrough;
  logic        is_alu_op_passthrough;
  logic        is_cmp_op_passthrough;
  logic        is_ld_op_passthrough;
  logic        err;

  int checks_total  = 0;
  int checks_passed = 0;

  memory_access #(
    .TIMEOUT (4)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .valid_in              (valid_in),
    .rd_num_in             (rd_num_in),
    .result_in             (result_in),
    .store_val_in          (store_val_in),
    .cpsr_in               (cpsr_in),
    .is_alu_op_in          (is_alu_op_in),
    .is_cmp_op_in          (is_cmp_op_in),
    .is_ld_op_in           (is_ld_op_in),
    .is_str_op_in          (is_str_op_in),
    .stall                 (stall),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_rdata            (dmem_rdata),
    .dmem_ack              (dmem_ack),
    .rd_num_passthrough    (rd_num_passthrough),
    .result                (result),
    .mem_passthrough       (mem_passthrough),
    .cpsr_passthrough      (cpsr_passthrough),
    .dmem_val_passthrough  (dmem_val_passthrough),
    .is_alu_op_passthrough (is_alu_op_passthrough),
    .is_cmp_op_passthrough (is_cmp_op_passthrough),
    .is_ld_op_passthrough  (is_ld_op_passthrough),
    .err                   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
      $display("ok   %s: 0x%08h", tag, obs);
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in     = 1'b0;
    rd_num_in    = '0;
    result_in    = '0;
    store_val_in = '0;
    cpsr_in      = '0;
    is_alu_op_in = 1'b0;
    is_cmp_op_in = 1'b0;
    is_ld_op_in  = 1'b0;
    is_str_op_in = 1'b0;
  endtask

  task automatic issue_ld(input logic [3:0] rd, input logic [31:0] addr);
    clear_inputs();
    valid_in    = 1'b1;
    rd_num_in   = rd;
    result_in   = addr;
    is_ld_op_in = 1'b1;
  endtask

  function automatic logic [31:0] pt_flags();
    return 32'({is_alu_op_passthrough, is_cmp_op_passthrough, is_ld_op_passthrough});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_flags", pt_flags(), 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU op, one-cycle latency
    valid_in = 1'b1; is_alu_op_in = 1'b1; rd_num_in = 4'd3;
    result_in = 32'h0000_00AA; cpsr_in = 32'h8000_0000;
    step();
    check("alu_rd", 32'(rd_num_passthrough), 32'd3);
    check("alu_result", result, 32'h0000_00AA);
    check("alu_mem_pt", mem_passthrough, 32'h0000_00AA);
    check("alu_flags", pt_flags(), 32'b100);
    check("alu_stall", 32'(stall), 32'd0);

    // Compare op carries cpsr
    clear_inputs();
    valid_in = 1'b1; is_cmp_op_in = 1'b1; rd_num_in = 4'd5;
    result_in = 32'h0000_0011; cpsr_in = 32'h6000_0000;
    step();
    check("cmp_flags", pt_flags(), 32'b010);
    check("cmp_cpsr", cpsr_passthrough, 32'h6000_0000);
    check("cmp_rd", 32'(rd_num_passthrough), 32'd5);

    // Load at 0x40, ack on third ACCESS cycle; next ALU op held upstream
    issue_ld(4'd7, 32'h0000_0040);
    step();
    clear_inputs();
    valid_in = 1'b1; is_alu_op_in = 1'b1; rd_num_in = 4'd9; result_in = 32'h0000_0055;
    check("ld_c1_stall", 32'(stall), 32'd1);
    check("ld_c1_req", 32'(dmem_req), 32'd1);
    check("ld_c1_we", 32'(dmem_we), 32'd0);
    check("ld_c1_addr", dmem_addr, 32'h0000_0040);
    check("ld_c1_flags", pt_flags(), 32'd0);
    step();
    check("ld_c2_stall", 32'(stall), 32'd1);
    check("ld_c2_addr", dmem_addr, 32'h0000_0040);
    step();
    check("ld_c3_stall", 32'(stall), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("ld_done_stall", 32'(stall), 32'd0);
    check("ld_done_req", 32'(dmem_req), 32'd0);
    check("ld_done_flags", pt_flags(), 32'b001);
    check("ld_done_val", dmem_val_passthrough, 32'hDEAD_BEEF);
    check("ld_done_rd", 32'(rd_num_passthrough), 32'd7);
    check("ld_done_mem_pt", mem_passthrough, 32'h0000_0040);
    step();
    check("held_alu_flags", pt_flags(), 32'b100);
    check("held_alu_rd", 32'(rd_num_passthrough), 32'd9);
    check("held_alu_result", result, 32'h0000_0055);
    clear_inputs();
    step();
    check("held_alu_nodup", pt_flags(), 32'd0);

    // Store at 0x80, zero-wait ack
    valid_in = 1'b1; is_str_op_in = 1'b1; rd_num_in = 4'd1;
    result_in = 32'h0000_0080; store_val_in = 32'h0000_1234;
    step();
    clear_inputs();
    check("str_we", 32'(dmem_we), 32'd1);
    check("str_req", 32'(dmem_req), 32'd1);
    check("str_wdata", dmem_wdata, 32'h0000_1234);
    check("str_addr", dmem_addr, 32'h0000_0080);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    check("str_done_req", 32'(dmem_req), 32'd0);
    check("str_done_we", 32'(dmem_we), 32'd0);
    check("str_done_stall", 32'(stall), 32'd0);
    check("str_done_flags", pt_flags(), 32'd0);

    // Ack while idle is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("idle_ack_stall", 32'(stall), 32'd0);
    check("idle_ack_req", 32'(dmem_req), 32'd0);
    check("idle_ack_flags", pt_flags(), 32'd0);
    check("idle_ack_err", 32'(err), 32'd0);

    // Timeout: load never acked, TIMEOUT=4
    issue_ld(4'd2, 32'h0000_0100);
    step();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_c%0d_req", i + 1), 32'(dmem_req), 32'd1);
      check($sformatf("to_c%0d_err", i + 1), 32'(err), 32'd0);
      step();
    end
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_err", 32'(err), 32'd1);
    check("to_stall", 32'(stall), 32'd0);
    check("to_flags", pt_flags(), 32'd0);
    step();
    check("to_err_pulse", 32'(err), 32'd0);

    // Ack on the final wait cycle wins over timeout
    issue_ld(4'd6, 32'h0000_0200);
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) step();
    check("race_c4_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0001;
    step();
    dmem_ack = 1'b0; dmem_rdata = '0;
    check("race_err", 32'(err), 32'd0);
    check("race_flags", pt_flags(), 32'b001);
    check("race_val", dmem_val_passthrough, 32'hCAFE_0001);

    // Illegal: ld and alu together
    valid_in = 1'b1; is_ld_op_in = 1'b1; is_alu_op_in = 1'b1; result_in = 32'h0000_0300;
    step();
    clear_inputs();
    check("ill_err", 32'(err), 32'd1);
    check("ill_req", 32'(dmem_req), 32'd0);
    check("ill_stall", 32'(stall), 32'd0);
    check("ill_flags", pt_flags(), 32'd0);
    step();
    check("ill_err_pulse", 32'(err), 32'd0);

    // Reset in the middle of an access
    issue_ld(4'd8, 32'h0000_0400);
    step();
    clear_inputs();
    check("mr_req_before", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_req", 32'(dmem_req), 32'd0);
    check("mr_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b1; is_alu_op_in = 1'b1; rd_num_in = 4'd4; result_in = 32'h0000_0077;
    step();
    clear_inputs();
    check("mr_alu_flags", pt_flags(), 32'b100);
    check("mr_alu_result", result, 32'h0000_0077);
    check("mr_alu_rd", 32'(rd_num_passthrough), 32'd4);
    check("mr_alu_stall", 32'(stall), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
